cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Multi-requester, multi-bus arbiter for the common data buses (CDBs).
- Each cycle it allocates up to CDB_COUNT buses among REQ_COUNT requesters using round-robin priority.
- It publishes the owner of each bus as a 4-bit device address; address 0 means the bus is disconnected/idle.
- Requesters may lock a bus for multi-cycle transfers, bounded by a hold timeout.
- Sits between the issue/execute units and the CDB multiplexers.

Parameters:
- CDB_COUNT, 2, number of common data buses (1..4).
- REQ_COUNT, 4, number of requesters (1..15). Requester i has device address i+1.
- MAX_HOLD, 4, maximum consecutive cycles one requester may own a bus (>=1).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  REQ_COUNT  bus request per requester.
- lock  in  REQ_COUNT  keep the currently owned bus next cycle (ignored if not an owner).
- bus_disable  in  CDB_COUNT  bus unavailable; the owner is dropped and no new grant is made.
- flush  in  1  release all buses, no new grants this cycle.
- grant  out  REQ_COUNT  requester owns a bus this cycle.
- grant_bus  out  REQ_COUNT*2  index of the owned bus per requester; 0 when not granted.
- select  out  4*CDB_COUNT  owner address per bus; nibble b belongs to bus b; 0 = idle.
- bus_busy  out  CDB_COUNT  select nibble b is non-zero.

Behaviour:
- Reset (async, reset_n=0): select=0, grant=0, grant_bus=0, bus_busy=0, rr_ptr=0, all hold counters=0. Reset mid-lock drops ownership immediately.
- All outputs are registered from state: owner[b] (4 bits) and hold_cnt[b] per bus.
- Latency: req sampled at edge k produces grant/select visible after edge k.
- Keep phase, per bus b owned by requester r:
  - The bus is kept if req[r] && lock[r] && hold_cnt[b] < MAX_HOLD-1 && !flush && !bus_disable[b]; then hold_cnt[b]++.
  - Otherwise it is freed at the edge.
- Timeout: a requester released by timeout is ineligible for a new grant at the same edge.
- Allocate phase (suppressed when flush=1):
  - Eligible requesters have req=1, do not keep a bus, and were not timed out this edge.
  - They are scanned from rr_ptr upward, modulo REQ_COUNT.
  - Free buses with bus_disable=0 are assigned in ascending index order.
  - A new grant sets hold_cnt=0.
  - Each requester owns at most one bus.
- rr_ptr: if any new allocation occurred, rr_ptr = (last newly granted index + 1) mod REQ_COUNT; otherwise unchanged. Kept buses do not move rr_ptr.
- A bus freed at an edge is reallocatable at that same edge, so no idle bubble appears under contention.
- More eligible requesters than buses: the excess requesters get no grant and must keep req high. No starvation: any continuously requesting requester is granted within ceil(REQ_COUNT/CDB_COUNT)*MAX_HOLD cycles.
- lock with req=0 releases the bus.
- lock from a non-owner has no effect.
- MAX_HOLD=1 means lock is effectively ignored.
- Invariant: no two buses carry the same non-zero address. The bench asserts this every cycle.

Decomposition:
- Shared package cdb_pkg holds:
  - CDB_ADDR_W=4 and CDB_IDLE=4'h0.
  - The type cdb_addr_t.
  - A function mapping a requester index to its address.
- One sub-module, rr_picker: a combinational round-robin selector that, given an eligibility vector and start pointer, returns the first eligible index with a valid flag. It is instantiated CDB_COUNT times in a cascade, each stage masking earlier picks.

Test Plan:
- Reset: hold reset_n=0 with req=4'b1111 -> all outputs 0. On release with req=4'b1111, after the first edge select={bus1=2, bus0=1}, grant=4'b0011, rr_ptr=2.
- Round-robin: req=4'b1111 held, lock=0 -> bus0/bus1 owners cycle through (1,2), (3,4), (1,2)… with each requester granted every second cycle.
- Lock and timeout: MAX_HOLD=4; req[0]=lock[0]=1 -> select bus0=1 for exactly 4 cycles, then 0 for one cycle (if req[0] is alone), then re-granted.
- Release/reuse: the owner of bus0 drops lock while req[2]=1 -> bus0=3 on the next edge with no idle cycle.
- bus_disable[1]=1 with req=4'b0011 -> only requester 0 is granted (bus0); requester 1 waits and is granted on bus1 the cycle after disable clears. Asserting flush mid-lock -> select=0 after the next edge.
- Async reset while bus0 is locked -> select=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/cdb_pkg.sv
// cdb_pkg: shared CDB address type, idle code and requester-to-address mapping
package cdb_pkg;
    localparam int CDB_ADDR_W = 4;

    typedef logic [CDB_ADDR_W-1:0] cdb_addr_t;

    localparam cdb_addr_t CDB_IDLE = 4'h0;

    function automatic cdb_addr_t req_addr(input int idx);
        return cdb_addr_t'(idx + 1);
    endfunction
endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// rr_picker: first eligible index at or after start, wrapping modulo N
module rr_picker #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  elig,
    input  logic [PW-1:0] start,
    output logic [PW-1:0] idx,
    output logic          valid
);
    // scan farthest-first so the closest eligible index to start wins
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (elig[(int'(start) + k) % N]) begin
                idx   = PW'((int'(start) + k) % N);
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin allocation of CDB_COUNT buses among REQ_COUNT requesters with bounded lock
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int CDB_COUNT = 2,
    parameter int REQ_COUNT = 4,
    parameter int MAX_HOLD  = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [REQ_COUNT-1:0]     req,
    input  logic [REQ_COUNT-1:0]     lock,
    input  logic [CDB_COUNT-1:0]     bus_disable,
    input  logic                     flush,
    output logic [REQ_COUNT-1:0]     grant,
    output logic [REQ_COUNT*2-1:0]   grant_bus,
    output logic [4*CDB_COUNT-1:0]   select,
    output logic [CDB_COUNT-1:0]     bus_busy
);
    localparam int PW = REQ_COUNT > 1 ? $clog2(REQ_COUNT) : 1;
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD - 1);

    cdb_addr_t                          owner    [CDB_COUNT];
    cdb_addr_t                          owner_n  [CDB_COUNT];
    logic [HW-1:0]                      hold_cnt [CDB_COUNT];
    logic [HW-1:0]                      hold_n   [CDB_COUNT];
    logic [PW-1:0]                      rr_ptr;
    logic [PW-1:0]                      rr_n;
    logic [CDB_COUNT-1:0]               keep;
    logic [REQ_COUNT-1:0]               kept_req;
    logic [REQ_COUNT-1:0]               to_req;
    logic [CDB_COUNT:0][REQ_COUNT-1:0]  stage_elig;
    logic [CDB_COUNT-1:0][PW-1:0]       pick_idx;
    logic [CDB_COUNT-1:0]               pick_valid;

    // keep phase: decide which owned buses survive the edge and who times out
    always_comb begin
        keep     = '0;
        kept_req = '0;
        to_req   = '0;
        for (int b = 0; b < CDB_COUNT; b++) begin
            for (int r = 0; r < REQ_COUNT; r++) begin
                if (owner[b] == req_addr(r)) begin
                    if (req[r] && lock[r] && !flush && !bus_disable[b] && hold_cnt[b] < HOLD_LIM) begin
                        keep[b]     = 1'b1;
                        kept_req[r] = 1'b1;
                    end
                    if (MAX_HOLD > 1 && req[r] && lock[r] && hold_cnt[b] >= HOLD_LIM)
                        to_req[r] = 1'b1;
                end
            end
        end
    end

    assign stage_elig[0] = flush ? '0 : req & ~kept_req & ~to_req;

    for (genvar g = 0; g < CDB_COUNT; g++) begin : g_pick
        rr_picker #(.N(REQ_COUNT), .PW(PW)) u_pick (
            .elig  (stage_elig[g]),
            .start (rr_ptr),
            .idx   (pick_idx[g]),
            .valid (pick_valid[g])
        );
        assign stage_elig[g+1] = stage_elig[g] & ~(REQ_COUNT'(pick_valid[g]) << pick_idx[g]);
    end

    // allocate phase: hand successive picks to free enabled buses in ascending order
    always_comb begin
        int n;
        n    = 0;
        rr_n = rr_ptr;
        for (int b = 0; b < CDB_COUNT; b++) begin
            owner_n[b] = keep[b] ? owner[b] : CDB_IDLE;
            hold_n[b]  = keep[b] ? hold_cnt[b] + 1'b1 : '0;
            if (!keep[b] && !bus_disable[b]) begin
                if (pick_valid[n]) begin
                    owner_n[b] = req_addr(int'(pick_idx[n]));
                    hold_n[b]  = '0;
                    rr_n       = (pick_idx[n] == PW'(REQ_COUNT - 1)) ? '0 : pick_idx[n] + 1'b1;
                end
                n++;
            end
        end
    end

    // state register; async reset drops every owner immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
            for (int b = 0; b < CDB_COUNT; b++) begin
                owner[b]    <= CDB_IDLE;
                hold_cnt[b] <= '0;
            end
        end else begin
            rr_ptr <= rr_n;
            for (int b = 0; b < CDB_COUNT; b++) begin
                owner[b]    <= owner_n[b];
                hold_cnt[b] <= hold_n[b];
            end
        end
    end

    // decode published views from the registered owners
    always_comb begin
        grant     = '0;
        grant_bus = '0;
        select    = '0;
        bus_busy  = '0;
        for (int b = 0; b < CDB_COUNT; b++) begin
            select[4*b +: 4] = owner[b];
            bus_busy[b]      = owner[b] != CDB_IDLE;
            for (int r = 0; r < REQ_COUNT; r++) begin
                if (owner[b] == req_addr(r)) begin
                    grant[r]           = 1'b1;
                    grant_bus[2*r +: 2] = 2'(b);
                end
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scoreboard bench for cdb_arbiter (2 buses, 4 requesters, MAX_HOLD=4)
module tb_cdb_arbiter;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] req, lock;
    logic [1:0] bus_disable;
    logic       flush;
    logic [3:0] grant;
    logic [7:0] grant_bus;
    logic [7:0] select;
    logic [1:0] bus_busy;

    typedef struct {
        logic [7:0] sel;
        logic [3:0] gnt;
        logic [7:0] gb;
        logic [1:0] busy;
        string      name;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;

    cdb_arbiter #(.CDB_COUNT(2), .REQ_COUNT(4), .MAX_HOLD(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .lock        (lock),
        .bus_disable (bus_disable),
        .flush       (flush),
        .grant       (grant),
        .grant_bus   (grant_bus),
        .select      (select),
        .bus_busy    (bus_busy)
    );

    always #5 clk = ~clk;

    // monitor: pop one expectation per edge and check the duplicate-owner invariant
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (reset_n) begin
            tests++;
            if (select[7:4] != 4'h0 && select[7:4] == select[3:0]) begin
                fails++;
                $display("FAIL dup_owner select=%h", select);
            end
        end
        if (q.size() > 0) begin
            e = q.pop_front();
            tests++;
            if ({select, grant, grant_bus, bus_busy} !== {e.sel, e.gnt, e.gb, e.busy}) begin
                fails++;
                $display("FAIL %s got sel=%h gnt=%b gb=%h busy=%b exp sel=%h gnt=%b gb=%h busy=%b",
                         e.name, select, grant, grant_bus, bus_busy, e.sel, e.gnt, e.gb, e.busy);
            end
        end
    end

    // drive at a negedge, queue the state expected after the following edge
    task automatic step(input logic [3:0] r, input logic [3:0] l, input logic [1:0] d, input logic f,
                        input logic [7:0] s, input logic [3:0] g, input logic [7:0] gb,
                        input logic [1:0] bb, input string nm);
        exp_t e;
        req = r; lock = l; bus_disable = d; flush = f;
        e.sel = s; e.gnt = g; e.gb = gb; e.busy = bb; e.name = nm;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic chk_zero(input string nm);
        tests++;
        if ({select, grant, grant_bus, bus_busy} !== 22'h0) begin
            fails++;
            $display("FAIL %s got sel=%h gnt=%b gb=%h busy=%b exp all zero", nm, select, grant, grant_bus, bus_busy);
        end
    endtask

    initial begin
        reset_n = 1'b0; req = 4'b1111; lock = 4'b0; bus_disable = 2'b0; flush = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset_hold");
        reset_n = 1'b1;
        step(4'b1111, 4'b0000, 2'b00, 1'b0, 8'h21, 4'b0011, 8'h04, 2'b11, "rr_first");
        step(4'b1111, 4'b0000, 2'b00, 1'b0, 8'h43, 4'b1100, 8'h40, 2'b11, "rr_second");
        step(4'b1111, 4'b0000, 2'b00, 1'b0, 8'h21, 4'b0011, 8'h04, 2'b11, "rr_third");
        step(4'b1111, 4'b0000, 2'b00, 1'b0, 8'h43, 4'b1100, 8'h40, 2'b11, "rr_fourth");
        step(4'b0000, 4'b0000, 2'b00, 1'b0, 8'h00, 4'b0000, 8'h00, 2'b00, "idle");
        step(4'b0001, 4'b0001, 2'b00, 1'b0, 8'h01, 4'b0001, 8'h00, 2'b01, "lock_c1");
        step(4'b0001, 4'b0001, 2'b00, 1'b0, 8'h01, 4'b0001, 8'h00, 2'b01, "lock_c2");
        step(4'b0001, 4'b0001, 2'b00, 1'b0, 8'h01, 4'b0001, 8'h00, 2'b01, "lock_c3");
        step(4'b0001, 4'b0001, 2'b00, 1'b0, 8'h01, 4'b0001, 8'h00, 2'b01, "lock_c4");
        step(4'b0001, 4'b0001, 2'b00, 1'b0, 8'h00, 4'b0000, 8'h00, 2'b00, "timeout_gap");
        step(4'b0001, 4'b0001, 2'b00, 1'b0, 8'h01, 4'b0001, 8'h00, 2'b01, "regrant");
        step(4'b0001, 4'b0001, 2'b00, 1'b0, 8'h01, 4'b0001, 8'h00, 2'b01, "regrant_hold");
        step(4'b0101, 4'b0000, 2'b00, 1'b0, 8'h13, 4'b0101, 8'h01, 2'b11, "release_reuse");
        step(4'b1000, 4'b0000, 2'b00, 1'b0, 8'h04, 4'b1000, 8'h00, 2'b01, "single_r3");
        step(4'b0000, 4'b0000, 2'b00, 1'b0, 8'h00, 4'b0000, 8'h00, 2'b00, "idle2");
        step(4'b0011, 4'b0001, 2'b10, 1'b0, 8'h01, 4'b0001, 8'h00, 2'b01, "disable_bus1");
        step(4'b0011, 4'b0001, 2'b00, 1'b0, 8'h21, 4'b0011, 8'h04, 2'b11, "enable_bus1");
        step(4'b0011, 4'b0011, 2'b00, 1'b0, 8'h21, 4'b0011, 8'h04, 2'b11, "both_locked");
        step(4'b0011, 4'b0011, 2'b00, 1'b1, 8'h00, 4'b0000, 8'h00, 2'b00, "flush");
        step(4'b0000, 4'b0000, 2'b00, 1'b0, 8'h00, 4'b0000, 8'h00, 2'b00, "after_flush");
        step(4'b0001, 4'b0001, 2'b00, 1'b0, 8'h01, 4'b0001, 8'h00, 2'b01, "lock_pre_reset");
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero("async_reset");
        @(negedge clk);
        chk_zero("reset_held");
        reset_n = 1'b1;
        step(4'b1111, 4'b0000, 2'b00, 1'b0, 8'h21, 4'b0011, 8'h04, 2'b11, "post_reset_rr");
        step(4'b0000, 4'b0000, 2'b00, 1'b0, 8'h00, 4'b0000, 8'h00, 2'b00, "final_idle");
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
